// File: rtl/tile_fetch_ctrl_if.sv
// DMA request/read channel and operand-buffer write channel of the tile fetch controller.
// The master side is the controller; the slave side is the DMA engine plus operand buffers.
interface tile_fetch_ctrl_if #(
   parameter int SIZE   = 16,
   parameter int ELEM_W = 8,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32
);
   localparam int BEATS = SIZE * ELEM_W / DATA_W;
   localparam int RW    = $clog2(SIZE);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic              dma_req;
   logic [ADDR_W-1:0] dma_addr;
   logic [7:0]        dma_len;
   logic              dma_ack;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;
   logic              buf_valid;
   logic              buf_sel;
   logic [RW-1:0]     buf_row;
   logic [BW-1:0]     buf_beat;
   logic [DATA_W-1:0] buf_data;

   modport master (
      output dma_req, dma_addr, dma_len, buf_valid, buf_sel, buf_row, buf_beat, buf_data,
      input  dma_ack, dma_rvalid, dma_rdata
   );

   modport slave (
      input  dma_req, dma_addr, dma_len, buf_valid, buf_sel, buf_row, buf_beat, buf_data,
      output dma_ack, dma_rvalid, dma_rdata
   );
endinterface

// File: rtl/tile_fetch_ctrl.sv
// Tiled matmul operand fetch: walks mb/nb/kb tiles, requests one DMA transfer per in-range
// tile row (A then B per k-step), masks out-of-range elements and synthesises zero rows.
module tile_fetch_ctrl #(
   parameter int SIZE   = 16,
   parameter int ELEM_W = 8,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr_base_a,
   input  logic [ADDR_W-1:0] addr_base_b,
   input  logic [ADDR_W-1:0] stride_a,
   input  logic [ADDR_W-1:0] stride_b,
   input  logic [15:0]       m,
   input  logic [15:0]       k,
   input  logic [15:0]       n,
   output logic              busy,
   output logic              done,
   output logic              tile_done,
   tile_fetch_ctrl_if.master bus
);
   localparam int EPB   = DATA_W / ELEM_W;
   localparam int BEATS = SIZE * ELEM_W / DATA_W;
   localparam int RW    = $clog2(SIZE);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CW    = 17;
   localparam int XW    = ADDR_W + 8;

   typedef enum logic [2:0] {IDLE, ROW_SEL, REQ, DATA, ZERO, ADV} state_t;
   state_t state, state_d;

   logic [ADDR_W-1:0] base_a_q, base_b_q, stride_a_q, stride_b_q, addr_q, row_addr;
   logic [CW-1:0]     m_q, k_q, n_q, mb, nb, kb;
   logic [CW-1:0]     ri, cb, row_lim, col_lim, col0, mb_nx, nb_nx, kb_nx;
   logic              sel, done_q, tile_done_q;
   logic [RW-1:0]     row;
   logic [BW-1:0]     beat;
   logic              beat_last, row_last, kb_wrap, nb_wrap, mb_wrap, zero_dim;
   logic [DATA_W-1:0] masked;

   assign zero_dim = (m == '0) || (k == '0) || (n == '0);

   always_comb begin
      ri       = sel ? kb + CW'(row) : mb + CW'(row);
      cb       = sel ? nb : kb;
      row_lim  = sel ? k_q : m_q;
      col_lim  = sel ? n_q : k_q;
      row_addr = (sel ? base_b_q : base_a_q)
               + ADDR_W'(ri) * (sel ? stride_b_q : stride_a_q)
               + ADDR_W'((XW'(cb) * XW'(ELEM_W)) >> 3);
      // element columns of the current beat; anything past the column limit reads as zero
      col0     = cb + CW'(beat) * CW'(EPB);
      masked   = bus.dma_rdata;
      for (int unsigned e = 0; e < EPB; e++) begin
         if (col0 + CW'(e) >= col_lim) masked[e*ELEM_W +: ELEM_W] = '0;
      end
      beat_last = (beat == BW'(BEATS - 1));
      row_last  = (row == RW'(SIZE - 1));
      kb_nx     = kb + CW'(SIZE);
      nb_nx     = nb + CW'(SIZE);
      mb_nx     = mb + CW'(SIZE);
      kb_wrap   = (kb_nx >= k_q);
      nb_wrap   = (nb_nx >= n_q);
      mb_wrap   = (mb_nx >= m_q);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d       = state;
      bus.dma_req   = 1'b0;
      bus.buf_valid = 1'b0;
      bus.buf_data  = '0;
      case (state)
         IDLE:    if (start && !zero_dim) state_d = ROW_SEL;
         ROW_SEL: state_d = (ri >= row_lim) ? ZERO : REQ;
         REQ: begin
            bus.dma_req = 1'b1;
            if (bus.dma_ack) state_d = DATA;
         end
         DATA: begin
            if (bus.dma_rvalid) begin
               bus.buf_valid = 1'b1;
               bus.buf_data  = masked;
               if (beat_last) state_d = ADV;
            end
         end
         ZERO: begin
            bus.buf_valid = 1'b1;
            if (beat_last) state_d = ADV;
         end
         ADV:     state_d = (row_last && sel && kb_wrap && nb_wrap && mb_wrap) ? IDLE : ROW_SEL;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         base_a_q <= '0; base_b_q <= '0; stride_a_q <= '0; stride_b_q <= '0;
         m_q <= '0; k_q <= '0; n_q <= '0;
         mb <= '0; nb <= '0; kb <= '0; sel <= 1'b0; row <= '0; beat <= '0;
         addr_q <= '0; done_q <= 1'b0; tile_done_q <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         tile_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  base_a_q <= addr_base_a; base_b_q <= addr_base_b;
                  stride_a_q <= stride_a; stride_b_q <= stride_b;
                  m_q <= {1'b0, m}; k_q <= {1'b0, k}; n_q <= {1'b0, n};
                  mb <= '0; nb <= '0; kb <= '0; sel <= 1'b0; row <= '0; beat <= '0;
                  if (zero_dim) done_q <= 1'b1;
               end
            end
            ROW_SEL: begin
               addr_q <= row_addr;
               beat   <= '0;
            end
            DATA:    if (bus.dma_rvalid) beat <= beat_last ? '0 : beat + 1'b1;
            ZERO:    beat <= beat_last ? '0 : beat + 1'b1;
            ADV: begin
               // nested wrap: row -> operand -> kb -> nb -> mb
               row <= row + 1'b1;
               if (row_last) begin
                  sel <= ~sel;
                  if (sel) begin
                     kb <= kb_wrap ? '0 : kb_nx;
                     if (kb_wrap) begin
                        tile_done_q <= 1'b1;
                        nb <= nb_wrap ? '0 : nb_nx;
                        if (nb_wrap) begin
                           mb <= mb_wrap ? '0 : mb_nx;
                           if (mb_wrap) done_q <= 1'b1;
                        end
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy         = (state != IDLE);
   assign done         = done_q;
   assign tile_done    = tile_done_q;
   assign bus.dma_addr = addr_q;
   assign bus.dma_len  = 8'(BEATS);
   assign bus.buf_sel  = sel;
   assign bus.buf_row  = row;
   assign bus.buf_beat = beat;
endmodule

// File: tb/tb_tile_fetch_ctrl.sv
// Scoreboard bench for tile_fetch_ctrl: a loop-level job model fills request/beat queues,
// a DMA responder feeds data, and a monitor pops and compares every request and buffer beat.
module tb_tile_fetch_ctrl;
   localparam int SIZE   = 16;
   localparam int ELEM_W = 8;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 32;
   localparam int EPB    = DATA_W / ELEM_W;
   localparam int BEATS  = SIZE * ELEM_W / DATA_W;
   localparam int LIMIT  = 20000;

   logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
   logic [31:0] addr_base_a = '0, addr_base_b = '0, stride_a = '0, stride_b = '0;
   logic [15:0] m = '0, k = '0, n = '0;
   logic        busy, done, tile_done;

   int errors = 0, checks = 0;
   int tile_cnt = 0, done_cnt = 0, req_cnt = 0, beat_cnt = 0, exp_tiles = 0;
   int ack_delay_fix = 0, cur_delay = 0, gaps = 0, stray_mode = 0;
   int left = 0, bidx = 0, wait_cnt = 0;
   bit mon_en = 1'b1, rv_real = 1'b0, prev_ack = 1'b0, prev_wait = 1'b0;
   logic [31:0] ack_addr = '0, cur_addr = '0, prev_addr = '0;

   logic [31:0] req_q[$];
   logic [69:0] beat_q[$];

   tile_fetch_ctrl_if #(.SIZE(SIZE), .ELEM_W(ELEM_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   tile_fetch_ctrl #(.SIZE(SIZE), .ELEM_W(ELEM_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .addr_base_a(addr_base_a), .addr_base_b(addr_base_b),
      .stride_a(stride_a), .stride_b(stride_b),
      .m(m), .k(k), .n(n),
      .busy(busy), .done(done), .tile_done(tile_done),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pat(input logic [31:0] a, input int b);
      logic [31:0] h;
      h = a * 32'h9E37_79B9 + 32'(b) * 32'h7F4A_7C15 + 32'h1234_5678;
      return {h ^ 32'hA5A5_5A5A, h * 32'h85EB_CA6B + a};
   endfunction

   // job model straight from the loop nest: every row, every beat, in issue order
   task automatic build(input int mm, kk, nn, input logic [31:0] ba, sa, bb, sb);
      logic [31:0] a;
      logic [63:0] d;
      int ri, cb, rl, cl;
      exp_tiles = 0;
      if (mm == 0 || kk == 0 || nn == 0) return;
      for (int mb = 0; mb < mm; mb += SIZE)
         for (int nb = 0; nb < nn; nb += SIZE) begin
            exp_tiles++;
            for (int kb = 0; kb < kk; kb += SIZE)
               for (int op = 0; op < 2; op++)
                  for (int r = 0; r < SIZE; r++) begin
                     ri = (op == 0) ? mb + r : kb + r;
                     cb = (op == 0) ? kb : nb;
                     rl = (op == 0) ? mm : kk;
                     cl = (op == 0) ? kk : nn;
                     a  = ((op == 0) ? ba : bb) + 32'(ri) * ((op == 0) ? sa : sb) + 32'(cb * ELEM_W / 8);
                     if (ri < rl) req_q.push_back(a);
                     for (int b = 0; b < BEATS; b++) begin
                        d = '0;
                        if (ri < rl) begin
                           d = pat(a, b);
                           for (int e = 0; e < EPB; e++)
                              if (cb + b * EPB + e >= cl) d[e*ELEM_W +: ELEM_W] = '0;
                        end
                        beat_q.push_back({1'(op), 4'(r), 1'(b), d});
                     end
                  end
         end
   endtask

   // DMA responder: acts just after each rising edge
   initial begin : dma_drv
      bus.dma_ack = 1'b0; bus.dma_rvalid = 1'b0; bus.dma_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (!rstn) begin
            left = 0; wait_cnt = 0; rv_real = 1'b0;
            bus.dma_ack = 1'b0; bus.dma_rvalid = 1'b0;
         end else begin
            prev_ack = bus.dma_ack;
            if (rv_real) begin left--; bidx++; end
            if (prev_ack) begin left = BEATS; bidx = 0; cur_addr = ack_addr; end
            bus.dma_ack = 1'b0; bus.dma_rvalid = 1'b0; rv_real = 1'b0;
            bus.dma_rdata = {$urandom, $urandom};
            if (bus.dma_req) begin
               if (wait_cnt >= cur_delay) begin
                  bus.dma_ack = 1'b1; ack_addr = bus.dma_addr; wait_cnt = 0;
                  cur_delay = (ack_delay_fix >= 0) ? ack_delay_fix : int'($urandom_range(0, 3));
               end else wait_cnt++;
            end
            if (left > 0) begin
               if (gaps == 0 || $urandom_range(0, 2) != 0) begin
                  bus.dma_rvalid = 1'b1; rv_real = 1'b1; bus.dma_rdata = pat(cur_addr, bidx);
               end
            end else if (stray_mode == 2 || (stray_mode == 1 && $urandom_range(0, 3) == 0)) begin
               bus.dma_rvalid = 1'b1;
            end
         end
      end
   end

   // monitor: samples on the falling edge
   initial begin : monitor
      logic [69:0] got;
      forever begin
         @(negedge clk);
         if (!rstn || !mon_en) prev_wait = 1'b0;
         else begin
            if (bus.dma_req) begin
               if (prev_wait) chk("req_addr_stable", bus.dma_addr, prev_addr);
               if (bus.dma_ack) begin
                  req_cnt++;
                  if (req_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL req_unexpected: got addr %0h expected no request", bus.dma_addr);
                  end else begin
                     chk("req_addr", bus.dma_addr, req_q.pop_front());
                     chk("req_len", bus.dma_len, BEATS);
                  end
               end
            end
            prev_wait = bus.dma_req && !bus.dma_ack;
            prev_addr = bus.dma_addr;
            if (bus.buf_valid) begin
               beat_cnt++;
               got = {bus.buf_sel, bus.buf_row, bus.buf_beat, bus.buf_data};
               if (beat_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL buf_unexpected: got %0h expected no beat", got);
               end else chk("buf_beat", got, beat_q.pop_front());
            end
            if (tile_done) tile_cnt++;
            if (done) done_cnt++;
         end
      end
   end

   task automatic launch(input int mm, kk, nn, input logic [31:0] ba, sa, bb, sb);
      @(posedge clk); #1;
      m = 16'(mm); k = 16'(kk); n = 16'(nn);
      addr_base_a = ba; stride_a = sa; addr_base_b = bb; stride_b = sb;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_job(input string tag, input int mm, kk, nn,
                          input logic [31:0] ba, sa, bb, sb, input int dly, input bit mid);
      int cyc, exp_req, exp_beats;
      req_q.delete(); beat_q.delete();
      build(mm, kk, nn, ba, sa, bb, sb);
      exp_req = req_q.size(); exp_beats = beat_q.size();
      tile_cnt = 0; done_cnt = 0; req_cnt = 0; beat_cnt = 0;
      ack_delay_fix = dly; cur_delay = (dly >= 0) ? dly : 0;
      launch(mm, kk, nn, ba, sa, bb, sb);
      @(negedge clk); #2;
      if (mm == 0 || kk == 0 || nn == 0) begin
         chk({tag, "_zero_done_next"}, done, 1'b1);
         chk({tag, "_zero_busy"}, busy, 1'b0);
      end else chk({tag, "_busy_after_start"}, busy, 1'b1);
      cyc = 0;
      while (done_cnt == 0 && cyc < LIMIT) begin
         @(negedge clk); #2;
         cyc++;
         if (mid && cyc == 40) start = 1'b1;
         if (mid && cyc == 41) start = 1'b0;
      end
      if (cyc >= LIMIT) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no done within %0d cycles expected done", tag, LIMIT);
      end
      repeat (6) @(negedge clk);
      #2;
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_tile_done_count"}, tile_cnt, exp_tiles);
      chk({tag, "_req_count"}, req_cnt, exp_req);
      chk({tag, "_beat_count"}, beat_cnt, exp_beats);
      chk({tag, "_busy_idle"}, busy, 1'b0);
   endtask

   task automatic reset_test();
      int cyc, sv;
      bit seen;
      gaps = 0; stray_mode = 0; ack_delay_fix = 0; cur_delay = 0;
      req_q.delete(); beat_q.delete();
      build(16, 16, 16, 32'h1000, 32'd16, 32'h8000, 32'd16);
      launch(16, 16, 16, 32'h1000, 32'd16, 32'h8000, 32'd16);
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < LIMIT) begin
         @(negedge clk); #2;
         cyc++;
         seen = bus.buf_valid && !bus.buf_sel && bus.buf_row == 4'd3 && bus.buf_beat == 1'b1;
      end
      chk("rst_reached_row3_beat1", seen, 1'b1);
      rstn = 1'b0; mon_en = 1'b0;
      #1;
      chk("rst_async_outputs",
          {busy, done, tile_done, bus.dma_req, bus.buf_valid, bus.buf_sel, bus.buf_row,
           bus.buf_beat, bus.dma_addr, bus.buf_data}, '0);
      @(negedge clk); @(negedge clk);
      rstn = 1'b1;
      req_q.delete(); beat_q.delete();
      mon_en = 1'b1; stray_mode = 2; sv = 0;
      repeat (8) begin
         @(negedge clk); #2;
         if (bus.buf_valid) sv++;
      end
      chk("rst_stray_rvalid_ignored", sv, 0);
      stray_mode = 0;
      run_job("after_rst", 16, 16, 16, 32'h1000, 32'd16, 32'h8000, 32'd16, 0, 1'b0);
   endtask

   initial begin
      #12;
      chk("reset_outputs",
          {busy, done, tile_done, bus.dma_req, bus.buf_valid, bus.dma_addr, bus.buf_data}, '0);
      @(negedge clk);
      rstn = 1'b1;
      run_job("base", 16, 16, 16, 32'h1000, 32'd16, 32'h8000, 32'd16, 0, 1'b0);
      run_job("m20", 20, 16, 16, 32'h1000, 32'd16, 32'h8000, 32'd16, 0, 1'b0);
      run_job("k12", 16, 12, 16, 32'h1000, 32'd16, 32'h8000, 32'd16, 0, 1'b0);
      run_job("m0", 0, 16, 16, 32'h1000, 32'd16, 32'h8000, 32'd16, 0, 1'b0);
      run_job("ack5", 16, 16, 16, 32'h2000, 32'h40, 32'h9000, 32'h20, 5, 1'b1);
      gaps = 1; stray_mode = 1;
      run_job("odd", 33, 7, 18, 32'hFFFF_FF00, 32'h30, 32'h4000, 32'h100, -1, 1'b0);
      reset_test();
      gaps = 1; stray_mode = 1;
      for (int i = 0; i < 4; i++)
         run_job("rnd", int'($urandom_range(1, 36)), int'($urandom_range(1, 36)), int'($urandom_range(1, 36)),
                 $urandom, $urandom, $urandom, $urandom, -1, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tile_fetch_ctrl.md
Name: tile_fetch_ctrl

Overview:
Successor to the accelerator's operand-fetch control. Walks a tiled M×K by K×N matrix product and issues one DMA request per tile row. A and B tiles are fetched alternately for every k-step of every output tile. The block forwards read beats to the operand buffers with out-of-range rows and elements zeroed, and generates zero rows locally without touching the DMA. It sits between the CSR block (bases, dims, strides, start) and the DMA engine / systolic operand buffers.

Parameters:
SIZE, 16, tile edge in elements; power of two, ≥2
ELEM_W, 8, element width in bits
DATA_W, 64, DMA beat width; SIZE*ELEM_W must be an integer multiple of DATA_W
ADDR_W, 32, byte-address width
Derived: EPB = DATA_W/ELEM_W elements per beat; BEATS = SIZE*ELEM_W/DATA_W beats per tile row

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle launch pulse; sampled only in IDLE
addr_base_a, addr_base_b  in  ADDR_W  byte base of A, B
stride_a, stride_b  in  ADDR_W  bytes between consecutive rows of A, B
m, k, n  in  16  matrix dims in elements
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at job end
tile_done  out  1  one-cycle pulse after the last B row of the last k-step of an output tile
dma_req  out  1  request valid
dma_addr  out  ADDR_W  row start byte address
dma_len  out  8  beat count; constant BEATS
dma_ack  in  1  request accepted when dma_req&dma_ack
dma_rvalid  in  1  read beat valid
dma_rdata  in  DATA_W  read beat
buf_valid  out  1  beat to operand buffer
buf_sel  out  1  0=A, 1=B
buf_row  out  log2(SIZE)  row within tile
buf_beat  out  log2(BEATS) (min 1)  beat within row
buf_data  out  DATA_W  masked beat

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Asserting rstn low mid-job aborts immediately; later dma_rvalid beats are ignored until a new start.
- On start in IDLE: latch bases, strides and dims. If m, k or n is 0, pulse done next cycle with no request. Otherwise go to ROW_SEL. start is ignored while busy.
- Loop order, outermost first: mb = 0,SIZE,.. < m; nb = 0,SIZE,.. < n; kb = 0,SIZE,.. < k; operand A then B; row r = 0..SIZE-1.
- A row: row index ri = mb+r, column base cb = kb, row limit m, column limit k.
- B row: ri = kb+r, cb = nb, row limit k, column limit n.
- ROW_SEL: if ri ≥ row limit go to ZERO, else go to REQ.
- REQ: dma_req=1 with dma_addr = base + ri*stride + cb*ELEM_W/8, computed mod 2^ADDR_W. Hold req and addr stable until ack. The DMA transfer accepted in the ack cycle; then go to DATA.
- DATA: each dma_rvalid beat is forwarded in the same cycle (combinational buf_valid/buf_data), with buf_beat incrementing. After BEATS beats go to ADV. dma_rvalid in any other state is ignored.
- ZERO: emit BEATS consecutive beats of buf_valid=1, buf_data=0, one per cycle, then ADV.
- Element mask: element e of beat b has column cb + b*EPB + e and occupies bits [e*ELEM_W +: ELEM_W]. It is zeroed if column ≥ column limit.
- ADV (1 cycle): increment r.
  - On r wrap, A→B.
  - On B wrap, increment kb.
  - On kb wrap, pulse tile_done and increment nb.
  - On nb wrap, increment mb.
  - On mb wrap, pulse done together with tile_done and go to IDLE; busy drops the same cycle.
  - Otherwise go to ROW_SEL.
- Counters use ≥17 bits so that mb+SIZE cannot overflow at m=0xFFFF.

Test Plan:
- SIZE=16, DATA_W=64, m=k=n=16, base_a=0x1000, stride_a=16, base_b=0x8000, stride_b=16, ack same cycle, rvalid continuous -> A addrs 0x1000..0x10F0, then B 0x8000..0x80F0; 64 buf beats; tile_done and done once.
- m=20, k=n=16 -> 2 tile_done. In the second tile, A rows 4..15 are zero beats with no dma_req (A requests 0x1100..0x1130 only); B refetched from 0x8000.
- k=12, m=n=16 -> each A row beat 1 has bytes 4..7 zero. B rows 12..15 are zero rows with 12 B requests. Data bytes 0..11 pass unchanged.
- m=0 (others 16), start -> done pulses the next cycle; dma_req never rises; busy stays 0.
- dma_ack delayed 5 cycles, plus start pulsed mid-job -> dma_req/dma_addr stable all 5 cycles; the second start has no effect on the sequence.
- rstn low during DATA beat 1 of row 3 -> all outputs 0 asynchronously. After release, stray rvalid produces no buf_valid. A new start restarts at base_a.
